accel_ctrl: RTL and testbench
=============================

ACCEL_CTRL -- requirements
Module: accel_ctrl

Interface
REQ-001 The block SHALL have parameter CMD_ADDR, default 16'hFF00, meaning the data-memory address whose CPU write launches a command.
REQ-002 The block SHALL have parameter STAT_ADDR, default 16'hFF04, meaning the data-memory address that receives the status word.
REQ-003 The block SHALL have parameter RD_LAT, default 1, meaning cycles from accel_addr valid to accel_rd_data valid (legal range 1-4).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 cpu_wrt_en  input  1  CPU data-memory write strobe (snooped).
REQ-008 cpu_addr  input  16  CPU data-memory byte address (snooped).
REQ-009 cpu_wrt_data  input  32  CPU write data; [15:0] = source block address, [31:16] = digest destination address.
REQ-010 accel_rd_data  input  512  64-byte block read from data memory at accel_addr.
REQ-011 accel_addr  output  16  data-memory address for block read or word write.
REQ-012 accel_wrt_data  output  32  data-memory write word.
REQ-013 accel_wrt_en  output  1  data-memory write strobe.
REQ-014 hash_block  output  512  block handed to the hash core; held stable from hash_start until hash_done.
REQ-015 hash_start  output  1  single-cycle start pulse to the hash core.
REQ-016 hash_done  input  1  single-cycle completion pulse from the hash core.
REQ-017 hash_digest  input  256  digest; valid in the cycle hash_done is high.
REQ-018 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The block SHALL accept a command when cpu_wrt_en=1 and cpu_addr=CMD_ADDR, capturing src=cpu_wrt_data[15:0] and dst=cpu_wrt_data[31:16].
REQ-020 FSM states SHALL be IDLE, FETCH, HASH, WRITE, STATUS.
REQ-021 IDLE->FETCH on an accepted command; accel_addr=src from the next cycle.
REQ-022 FETCH SHALL hold accel_addr=src for RD_LAT cycles, then register accel_rd_data into hash_block and go to HASH.
REQ-023 hash_start SHALL pulse for exactly the first HASH cycle.
REQ-024 HASH SHALL wait indefinitely for hash_done; on hash_done it registers hash_digest and goes to WRITE.
REQ-025 WRITE SHALL drive 8 consecutive cycles with accel_wrt_en=1, accel_addr=dst+4*i, and accel_wrt_data=digest[255-32*i -: 32] for i=0..7, with the most significant word first.
REQ-026 Address arithmetic SHALL be 16-bit modulo 2^16 (dst=16'hFFF0 wraps to 16'h000C on the last word).
REQ-027 STATUS SHALL drive one cycle with accel_wrt_en=1, accel_addr=STAT_ADDR, accel_wrt_data={30'h0, ovr, 1'b1}, then return to IDLE.
REQ-028 ovr SHALL be a sticky flag, set when a command is snooped while busy=1; the dropped command SHALL have no effect.
REQ-029 ovr SHALL be cleared in the cycle its status word is written.
REQ-030 A command snooped in the same cycle the FSM returns to IDLE from STATUS SHALL be dropped and set ovr.
REQ-031 A command snooped in the IDLE cycle itself SHALL be accepted.
REQ-032 hash_done outside HASH SHALL be ignored, and hash_done coincident with hash_start SHALL NOT be accepted.
REQ-033 Outside FETCH/WRITE/STATUS, accel_addr, accel_wrt_data and accel_wrt_en SHALL be 0.
REQ-034 End-to-end latency from command to status write SHALL be 1+RD_LAT+1+H+8+1 cycles, where H is the hash_done wait.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE and set busy, hash_start, accel_wrt_en, accel_addr, accel_wrt_data, hash_block and ovr to 0, including when reset is asserted mid-command.
REQ-036 After reset the block SHALL write no partial digest or status words.

Verification
REQ-037 Basic: write 32'h0200_0100 to 16'hFF00, memory[0x100]=known block, core returns digest 256'h0123..CDEF after 10 cycles -> words written to 0x200..0x21C MSW first, then status 32'h1 to 0xFF04, busy low next cycle.
REQ-038 Overrun: second command during HASH -> ignored, status written = 32'h3, next command status = 32'h1.
REQ-039 Wrap: dst=16'hFFF0 -> last digest word at 16'h000C.
REQ-040 RD_LAT=3: hash_block equals memory contents at src, hash_start asserted exactly 4 cycles after command accept.
REQ-041 Reset during WRITE after 3 words: no further accel_wrt_en, all outputs 0 asynchronously, new command afterwards completes normally.
REQ-042 Spurious hash_done in IDLE/FETCH -> no state change; non-CMD_ADDR CPU writes -> no command accepted.

Source files
------------

// File: rtl/accel_ctrl.sv
// accel_ctrl: snoops CPU writes to a command address and sequences one
// hash job: fetch a 64-byte block, hand it to the hash core, write the
// 256-bit digest back as eight 32-bit words, then write a status word.
// All outputs are registered and cleared asynchronously by rst_n.
module accel_ctrl #(
  parameter logic [15:0] CMD_ADDR  = 16'hFF00,
  parameter logic [15:0] STAT_ADDR = 16'hFF04,
  parameter int          RD_LAT    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cpu_wrt_en,
  input  logic [15:0]  cpu_addr,
  input  logic [31:0]  cpu_wrt_data,
  input  logic [511:0] accel_rd_data,
  output logic [15:0]  accel_addr,
  output logic [31:0]  accel_wrt_data,
  output logic         accel_wrt_en,
  output logic [511:0] hash_block,
  output logic         hash_start,
  input  logic         hash_done,
  input  logic [255:0] hash_digest,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    HASH   = 3'd2,
    WRITE  = 3'd3,
    STATUS = 3'd4
  } state_t;

  state_t         state;
  logic [15:0]    dst;
  logic [255:0]   digest;
  logic [2:0]     cnt;
  logic           ovr;
  logic           cmd_hit;

  // Word idx of the digest, most significant word first.
  function automatic logic [31:0] digest_word(input logic [255:0] d,
                                              input logic [2:0]   idx);
    logic [255:0] sh;
    sh = d << {idx, 5'b00000};
    return sh[255:224];
  endfunction

  // A snooped CPU write to the command address.
  assign cmd_hit = cpu_wrt_en && (cpu_addr == CMD_ADDR);

  // Command sequencer: state, job registers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      dst            <= 16'h0000;
      digest         <= 256'h0;
      cnt            <= 3'd0;
      ovr            <= 1'b0;
      busy           <= 1'b0;
      hash_start     <= 1'b0;
      hash_block     <= 512'h0;
      accel_addr     <= 16'h0000;
      accel_wrt_data <= 32'h0000_0000;
      accel_wrt_en   <= 1'b0;
    end else begin
      hash_start <= 1'b0;
      case (state)
        IDLE: begin
          accel_addr     <= 16'h0000;
          accel_wrt_data <= 32'h0000_0000;
          accel_wrt_en   <= 1'b0;
          if (cmd_hit) begin
            dst        <= cpu_wrt_data[31:16];
            accel_addr <= cpu_wrt_data[15:0];
            cnt        <= 3'd0;
            busy       <= 1'b1;
            state      <= FETCH;
          end else begin
            busy <= 1'b0;
          end
        end
        FETCH: begin
          if (cmd_hit) ovr <= 1'b1;
          if (cnt == 3'(RD_LAT - 1)) begin
            hash_block <= accel_rd_data;
            hash_start <= 1'b1;
            accel_addr <= 16'h0000;
            state      <= HASH;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        HASH: begin
          if (cmd_hit) ovr <= 1'b1;
          // A done pulse in the start cycle belongs to no job of ours.
          if (hash_done && !hash_start) begin
            digest         <= hash_digest;
            accel_wrt_en   <= 1'b1;
            accel_addr     <= dst;
            accel_wrt_data <= hash_digest[255:224];
            cnt            <= 3'd0;
            state          <= WRITE;
          end else begin
            accel_wrt_en <= 1'b0;
          end
        end
        WRITE: begin
          if (cnt == 3'd7) begin
            // Status captures any overrun snooped up to and including now.
            accel_addr     <= STAT_ADDR;
            accel_wrt_data <= {30'h0, (ovr | cmd_hit), 1'b1};
            ovr            <= ovr | cmd_hit;
            state          <= STATUS;
          end else begin
            if (cmd_hit) ovr <= 1'b1;
            accel_addr     <= accel_addr + 16'd4;
            accel_wrt_data <= digest_word(digest, cnt + 3'd1);
            cnt            <= cnt + 3'd1;
          end
        end
        STATUS: begin
          // The status word reported ovr; only a command dropped right now survives.
          ovr            <= cmd_hit;
          accel_addr     <= 16'h0000;
          accel_wrt_data <= 32'h0000_0000;
          accel_wrt_en   <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          accel_addr     <= 16'h0000;
          accel_wrt_data <= 32'h0000_0000;
          accel_wrt_en   <= 1'b0;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_ctrl.sv
// tb_accel_ctrl: table-driven directed test of accel_ctrl (RD_LAT=1) plus
// hand-written sequences for an RD_LAT=3 instance and mid-write reset.
module tb_accel_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_wrt_en, cpu_wrt_en3;
  logic [15:0]  cpu_addr;
  logic [31:0]  cpu_wrt_data;
  logic [511:0] accel_rd_data, accel_rd_data3;
  logic [15:0]  accel_addr, accel_addr3;
  logic [31:0]  accel_wrt_data, accel_wrt_data3;
  logic         accel_wrt_en, accel_wrt_en3;
  logic [511:0] hash_block, hash_block3;
  logic         hash_start, hash_start3;
  logic         hash_done, hash_done3;
  logic [255:0] hash_digest;
  logic         busy, busy3;

  logic [15:0]  mem_addr, mem_addr3;
  logic [511:0] mem_blk, mem_blk3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Data memory model: the block at the single loaded address, junk elsewhere.
  assign accel_rd_data  = (accel_addr  == mem_addr)  ? mem_blk  : {16{32'hBAD0_BAD0}};
  assign accel_rd_data3 = (accel_addr3 == mem_addr3) ? mem_blk3 : {16{32'hBAD0_BAD0}};

  accel_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_wrt_en(cpu_wrt_en), .cpu_addr(cpu_addr),
    .cpu_wrt_data(cpu_wrt_data), .accel_rd_data(accel_rd_data),
    .accel_addr(accel_addr), .accel_wrt_data(accel_wrt_data),
    .accel_wrt_en(accel_wrt_en), .hash_block(hash_block),
    .hash_start(hash_start), .hash_done(hash_done),
    .hash_digest(hash_digest), .busy(busy)
  );

  accel_ctrl #(.RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cpu_wrt_en(cpu_wrt_en3), .cpu_addr(cpu_addr),
    .cpu_wrt_data(cpu_wrt_data), .accel_rd_data(accel_rd_data3),
    .accel_addr(accel_addr3), .accel_wrt_data(accel_wrt_data3),
    .accel_wrt_en(accel_wrt_en3), .hash_block(hash_block3),
    .hash_start(hash_start3), .hash_done(hash_done3),
    .hash_digest(hash_digest), .busy(busy3)
  );

  typedef struct {
    logic [31:0]  cmd;
    int           h;
    logic [255:0] dig;
    logic [511:0] blk;
    bit           ovr;
    bit           early;
    int           rst_w;
    logic [15:0]  exp_last;
    logic [31:0]  exp_stat;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    logic [15:0] src;
    logic [15:0] dst;
    int k;
    int n;
    src = v.cmd[15:0];
    dst = v.cmd[31:16];
    mem_addr = src;
    mem_blk  = v.blk;
    @(negedge clk);
    cpu_wrt_en = 1'b1; cpu_addr = 16'hFF00; cpu_wrt_data = v.cmd;
    @(negedge clk);
    k = 1;
    cpu_wrt_en = 1'b0;
    chk("fetch_addr", 512'(accel_addr), 512'(src));
    chk("fetch_busy", 512'(busy), 512'(1'b1));
    n = 0;
    while (!hash_start && n < 20) begin
      @(negedge clk); k++; n++;
    end
    chk("hash_start_seen", 512'(hash_start), 512'(1'b1));
    chk("hash_block", hash_block, v.blk);
    for (int i = 0; i < v.h; i++) begin
      if (i == 0 && v.early) begin
        hash_done = 1'b1; hash_digest = ~v.dig;
      end
      if (i == 0 && v.ovr) begin
        cpu_wrt_en = 1'b1; cpu_addr = 16'hFF00; cpu_wrt_data = 32'h0900_0900;
      end
      @(negedge clk); k++;
      hash_done = 1'b0; cpu_wrt_en = 1'b0;
      if (i == 0 && v.early) begin
        chk("early_done_ignored", 512'(accel_wrt_en), 512'(1'b0));
        chk("early_done_busy", 512'(busy), 512'(1'b1));
      end
    end
    hash_done = 1'b1; hash_digest = v.dig;
    @(negedge clk); k++;
    hash_done = 1'b0; hash_digest = 256'h0;
    for (int w = 0; w < 8; w++) begin
      chk("word_en", 512'(accel_wrt_en), 512'(1'b1));
      chk("word_addr", 512'(accel_addr), 512'(16'(dst + 16'(4 * w))));
      chk("word_data", 512'(accel_wrt_data), 512'(v.dig[255 - 32 * w -: 32]));
      if (w == 7) chk("last_addr", 512'(accel_addr), 512'(v.exp_last));
      if (v.rst_w != 0 && w == v.rst_w - 1) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 512'(busy), 512'(1'b0));
        chk("rst_start", 512'(hash_start), 512'(1'b0));
        chk("rst_wrt_en", 512'(accel_wrt_en), 512'(1'b0));
        chk("rst_addr", 512'(accel_addr), 512'(16'h0000));
        chk("rst_data", 512'(accel_wrt_data), 512'(32'h0000_0000));
        chk("rst_block", hash_block, 512'h0);
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          if (c == 2) rst_n = 1'b1;
          chk("post_rst_no_write", 512'(accel_wrt_en), 512'(1'b0));
          chk("post_rst_idle", 512'(busy), 512'(1'b0));
        end
        return;
      end
      @(negedge clk); k++;
    end
    chk("stat_en", 512'(accel_wrt_en), 512'(1'b1));
    chk("stat_addr", 512'(accel_addr), 512'(16'hFF04));
    chk("stat_data", 512'(accel_wrt_data), 512'(v.exp_stat));
    chk("latency", 512'(k + 1), 512'(1 + 1 + 1 + v.h + 8 + 1));
    @(negedge clk);
    chk("done_busy", 512'(busy), 512'(1'b0));
    chk("done_wrt_en", 512'(accel_wrt_en), 512'(1'b0));
    chk("done_addr", 512'(accel_addr), 512'(16'h0000));
    chk("done_data", 512'(accel_wrt_data), 512'(32'h0000_0000));
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] stat3;
    bit          stat3_seen;
    vt[0] = '{32'h0200_0100, 10,
              256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF,
              {16{32'h1111_2222}}, 1'b0, 1'b0, 0, 16'h021C, 32'h0000_0001};
    vt[1] = '{32'h0300_0140, 5,
              256'hFEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0_1122334455667788,
              {16{32'h3333_4444}}, 1'b1, 1'b0, 0, 16'h031C, 32'h0000_0003};
    vt[2] = '{32'h0400_0180, 2,
              256'hAAAA0000BBBB1111_CCCC2222DDDD3333_EEEE4444FFFF5555_0000666611117777,
              {16{32'h5555_6666}}, 1'b0, 1'b0, 0, 16'h041C, 32'h0000_0001};
    vt[3] = '{32'hFFF0_0040, 1,
              256'h1000000120000002_3000000340000004_5000000560000006_7000000780000008,
              {16{32'h7777_8888}}, 1'b0, 1'b0, 0, 16'h000C, 32'h0000_0001};
    vt[4] = '{32'h0500_0200, 3,
              256'hDEADBEEFCAFEF00D_0BADC0DE12345678_9ABCDEF013579BDF_2468ACE0FFFF0000,
              {16{32'h9999_AAAA}}, 1'b0, 1'b1, 0, 16'h051C, 32'h0000_0001};
    vt[5] = '{32'h0600_0240, 4,
              256'h5A5A5A5AA5A5A5A5_3C3C3C3CC3C3C3C3_0F0F0F0FF0F0F0F0_6969696996969696,
              {16{32'hBBBB_CCCC}}, 1'b1, 1'b0, 3, 16'h0000, 32'h0000_0000};
    vt[6] = '{32'h0800_0280, 6,
              256'h0000000100000002_0000000300000004_0000000500000006_0000000700000008,
              {16{32'hDDDD_EEEE}}, 1'b0, 1'b0, 0, 16'h081C, 32'h0000_0001};

    rst_n = 1'b0;
    cpu_wrt_en = 1'b0; cpu_wrt_en3 = 1'b0;
    cpu_addr = 16'h0000; cpu_wrt_data = 32'h0;
    hash_done = 1'b0; hash_done3 = 1'b0; hash_digest = 256'h0;
    mem_addr = 16'h0000; mem_addr3 = 16'h0000;
    mem_blk = 512'h0; mem_blk3 = 512'h0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 512'(busy), 512'(1'b0));
    chk("reset_wrt_en", 512'(accel_wrt_en), 512'(1'b0));
    chk("reset_addr", 512'(accel_addr), 512'(16'h0000));
    chk("reset_block", hash_block, 512'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Spurious hash_done in IDLE and writes to other addresses start nothing.
    hash_done = 1'b1;
    @(negedge clk);
    hash_done = 1'b0;
    cpu_wrt_en = 1'b1; cpu_addr = 16'hFF04; cpu_wrt_data = 32'h0200_0100;
    @(negedge clk);
    cpu_addr = 16'hFF01;
    @(negedge clk);
    cpu_wrt_en = 1'b0;
    chk("spurious_busy", 512'(busy), 512'(1'b0));
    chk("spurious_start", 512'(hash_start), 512'(1'b0));
    @(negedge clk);
    chk("noncmd_busy", 512'(busy), 512'(1'b0));
    chk("noncmd_wrt_en", 512'(accel_wrt_en), 512'(1'b0));

    for (int t = 0; t < 7; t++) run_cmd(vt[t]);

    // RD_LAT=3 instance: start 4 cycles after accept, fetch ignores hash_done.
    mem_addr3 = 16'h0500;
    mem_blk3  = {8{64'h0123_4567_89AB_CDEF}};
    @(negedge clk);
    cpu_wrt_en3 = 1'b1; cpu_addr = 16'hFF00; cpu_wrt_data = 32'h0600_0500;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      cpu_wrt_en3 = 1'b0;
      hash_done3 = (c == 2);
      chk("lat3_start_timing", 512'(hash_start3), 512'(c == 4));
      if (c == 1) chk("lat3_addr", 512'(accel_addr3), 512'(16'h0500));
    end
    hash_done3 = 1'b0;
    chk("lat3_block", hash_block3, {8{64'h0123_4567_89AB_CDEF}});
    @(negedge clk);
    hash_done3 = 1'b1; hash_digest = 256'h1;
    @(negedge clk);
    hash_done3 = 1'b0; hash_digest = 256'h0;
    stat3 = 32'h0; stat3_seen = 1'b0;
    for (int c = 0; c < 20 && busy3; c++) begin
      if (accel_wrt_en3 && accel_addr3 == 16'hFF04) begin
        stat3 = accel_wrt_data3; stat3_seen = 1'b1;
      end
      @(negedge clk);
    end
    chk("lat3_status_seen", 512'(stat3_seen), 512'(1'b1));
    chk("lat3_status", 512'(stat3), 512'(32'h0000_0001));
    chk("lat3_idle", 512'(busy3), 512'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
